// File: rtl/vec_unit_arbiter.sv
// Round-robin arbiter that lends one chunked vector unit to NumReq requester FIFOs,
// one whole vector per grant, sequencing chunk pops, ROM chunk address and result pushes.
module vec_unit_arbiter #(
  parameter int NumReq      = 2,
  parameter int InVecLength = 16,
  parameter int WorkingRegs = 4,
  localparam int ChunksPerVec = InVecLength / WorkingRegs,
  localparam int SelW         = $clog2(NumReq),
  localparam int IdxW         = (ChunksPerVec > 1) ? $clog2(ChunksPerVec) : 1
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [NumReq-1:0] vec_ready_in,
  input  logic              out_afull_in,
  output logic [NumReq-1:0] grant_out,
  output logic [SelW-1:0]   src_sel_out,
  output logic              chunk_rd_out,
  output logic [IdxW-1:0]   chunk_idx_out,
  output logic              chunk_wr_out,
  output logic              vec_done_out,
  output logic              busy_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic [SelW-1:0] LastReset = SelW'(NumReq - 1);
  localparam logic [IdxW-1:0] LastChunk = IdxW'(ChunksPerVec - 1);

  state_e              state_q, state_d;
  logic [NumReq-1:0]   grant_q, grant_d;
  logic [SelW-1:0]     sel_q, sel_d;
  logic [SelW-1:0]     last_q, last_d;
  logic [IdxW-1:0]     cnt_q, cnt_d;
  logic                wr_q, wr_d;
  logic                chunk_rd;
  logic [SelW-1:0]     pick;

  // First requesting index after last_grant, wrapping modulo NumReq.
  function automatic logic [SelW-1:0] rr_pick(input logic [NumReq-1:0] req,
                                              input logic [SelW-1:0]   last);
    int cand;
    rr_pick = '0;
    for (int k = NumReq; k >= 1; k--) begin
      cand = int'(last) + k;
      if (cand >= NumReq) cand = cand - NumReq;
      if (req[cand]) rr_pick = SelW'(cand);
    end
  endfunction

  always_comb begin
    pick = rr_pick(vec_ready_in, last_q);
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    sel_d    = sel_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    chunk_rd = 1'b0;
    case (state_q)
      IDLE: begin
        if (|vec_ready_in) begin
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          sel_d         = pick;
          last_d        = pick;
          state_d       = RUN;
        end
      end
      RUN: begin
        // The granted requester's ready is ignored here: it drops as its FIFO drains.
        chunk_rd = !out_afull_in;
        if (chunk_rd) begin
          if (cnt_q == LastChunk) begin
            cnt_d   = '0;
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_q + IdxW'(1);
          end
        end
      end
      DRAIN: begin
        grant_d = '0;
        sel_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // FIFO and ROM both answer one cycle after the pop, so the push trails by one.
    wr_d = chunk_rd;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      last_q  <= LastReset;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
    end
  end

  assign grant_out     = grant_q;
  assign src_sel_out   = sel_q;
  assign chunk_rd_out  = chunk_rd;
  assign chunk_idx_out = cnt_q;
  assign chunk_wr_out  = wr_q;
  assign vec_done_out  = (state_q == DRAIN);
  assign busy_out      = (state_q != IDLE);

  a_grant_onehot: assert property (@(posedge clk_in) disable iff (!rst_in)
    $onehot0(grant_q));
  a_rd_only_in_run: assert property (@(posedge clk_in) disable iff (!rst_in)
    chunk_rd |-> (state_q == RUN));
  a_grant_while_busy: assert property (@(posedge clk_in) disable iff (!rst_in)
    (state_q != IDLE) |-> (grant_q != '0));

endmodule

// File: tb/tb_vec_unit_arbiter.sv
// Self-checking bench for vec_unit_arbiter: directed cases plus a queue scoreboard
// of popped chunks against pushed results under random ready/backpressure.
module tb_vec_unit_arbiter;

  localparam int NR  = 2;
  localparam int CPV = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NR-1:0] rdy;
  logic          af;
  logic [NR-1:0] grant;
  logic [0:0]    sel;
  logic          rd;
  logic [1:0]    idx;
  logic          wr;
  logic          done;
  logic          busy;

  logic [NR-1:0] rdy1;
  logic          af1;
  logic [NR-1:0] grant1;
  logic [0:0]    sel1;
  logic          rd1;
  logic [0:0]    idx1;
  logic          wr1;
  logic          done1;
  logic          busy1;

  always #5 clk = ~clk;

  vec_unit_arbiter #(.NumReq(NR), .InVecLength(16), .WorkingRegs(4)) u_dut (
    .clk_in(clk), .rst_in(rst_n), .vec_ready_in(rdy), .out_afull_in(af),
    .grant_out(grant), .src_sel_out(sel), .chunk_rd_out(rd), .chunk_idx_out(idx),
    .chunk_wr_out(wr), .vec_done_out(done), .busy_out(busy)
  );

  vec_unit_arbiter #(.NumReq(NR), .InVecLength(4), .WorkingRegs(4)) u_dut1 (
    .clk_in(clk), .rst_in(rst_n), .vec_ready_in(rdy1), .out_afull_in(af1),
    .grant_out(grant1), .src_sel_out(sel1), .chunk_rd_out(rd1), .chunk_idx_out(idx1),
    .chunk_wr_out(wr1), .vec_done_out(done1), .busy_out(busy1)
  );

  typedef struct {
    int src;
    int idx;
  } rec_t;

  int   errors = 0;
  int   checks = 0;
  rec_t sb_q[$];
  int   m_st, m_src, m_idx, m_last, m_wr;
  int   seq[NR];
  int   skip[NR];
  logic prev_busy;
  logic [NR-1:0] prev_r;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_src = 0; m_idx = 0; m_last = NR - 1; m_wr = 0;
    sb_q.delete();
    for (int i = 0; i < NR; i++) begin
      seq[i]  = 0;
      skip[i] = 0;
    end
    prev_busy = 1'b0;
    prev_r    = '0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_sel"},   sel,   0);
    chk({tag, "_rd"},    rd,    0);
    chk({tag, "_idx"},   idx,   0);
    chk({tag, "_wr"},    wr,    0);
    chk({tag, "_done"},  done,  0);
    chk({tag, "_busy"},  busy,  0);
  endtask

  // One clock of DUT0: drive at negedge, sample 1 later, check, then advance the model.
  task automatic step(input logic [NR-1:0] r, input logic a);
    logic [NR-1:0] eg;
    logic          erd;
    int            pick;
    int            c;
    rec_t          e;
    @(negedge clk);
    rdy = r;
    af  = a;
    #1;
    eg  = (m_st != 0) ? NR'(1 << m_src) : '0;
    erd = (m_st == 1) && !a;
    chk("grant",   grant, eg);
    chk("src_sel", sel,   (m_st != 0) ? m_src : 0);
    chk("rd",      rd,    erd);
    chk("idx",     idx,   m_idx);
    chk("wr",      wr,    m_wr);
    chk("done",    done,  m_st == 2);
    chk("busy",    busy,  m_st != 0);
    if (wr) begin
      if (sb_q.size() == 0) begin
        chk("sb_push_without_pop", 1, 0);
      end else begin
        e = sb_q.pop_front();
        chk("sb_src", sel, e.src);
        chk("sb_order", e.idx, seq[e.src]);
        seq[e.src] = (seq[e.src] + 1) % CPV;
      end
    end
    if (done) chk("sb_vec_complete", seq[sel], 0);
    if (busy && !prev_busy) begin
      for (int i = 0; i < NR; i++) begin
        if (grant[i]) begin
          skip[i] = 0;
        end else if (prev_r[i]) begin
          skip[i]++;
          chk($sformatf("starve%0d", i), skip[i] <= NR - 1, 1);
        end
      end
    end
    prev_busy = busy;
    prev_r    = r;
    if (erd) sb_q.push_back('{m_src, m_idx});
    m_wr = erd;
    case (m_st)
      0: if (r != 0) begin
        pick = -1;
        for (int k = 1; k <= NR; k++) begin
          c = (m_last + k) % NR;
          if (pick < 0 && r[c]) pick = c;
        end
        m_src = pick; m_last = pick; m_st = 1;
      end
      1: if (erd) begin
        if (m_idx == CPV - 1) begin
          m_idx = 0; m_st = 2;
        end else begin
          m_idx++;
        end
      end
      default: m_st = 0;
    endcase
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NR-1:0] exp_rr[4];
    logic          af_tab[10];
    int nv, cyc, gcount, idle_cnt, nw, nd, nb, ip;
    logic first, was_busy;

    exp_rr = '{2'b01, 2'b10, 2'b01, 2'b10};
    af_tab = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0; rdy = '0; af = 1'b0; rdy1 = '0; af1 = 1'b0;
    #3;
    chk_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Single-chunk vectors on the second instance.
    @(negedge clk); rdy1 = 2'b01; #1;
    chk("c1_idle_busy", busy1, 0);
    @(negedge clk); rdy1 = '0; #1;
    chk("c1_rd", rd1, 1);
    chk("c1_idx", idx1, 0);
    chk("c1_grant", grant1, 2'b01);
    chk("c1_wr_early", wr1, 0);
    @(negedge clk); #1;
    chk("c1_wr", wr1, 1);
    chk("c1_done", done1, 1);
    chk("c1_rd_drain", rd1, 0);
    @(negedge clk); #1;
    chk("c1_busy_end", busy1, 0);
    chk("c1_grant_end", grant1, 0);

    // Asynchronous reset in the middle of a vector.
    step(2'b01, 1'b0);
    step(2'b00, 1'b0);
    step(2'b00, 1'b0);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Both requesting: requester 0 first after reset, then strict alternation.
    nv = 0; cyc = 0; gcount = 0; idle_cnt = 0; first = 1'b1; was_busy = 1'b0;
    while (nv < 4 && cyc < 100) begin
      step(2'b11, 1'b0);
      cyc++;
      if (busy && !was_busy) begin
        if (gcount < 4) chk($sformatf("rr_grant%0d", gcount), grant, exp_rr[gcount]);
        if (!first) chk("rr_gap", idle_cnt, 1);
        first = 1'b0;
        gcount++;
        idle_cnt = 0;
      end
      if (!busy) idle_cnt++;
      if (done) nv++;
      was_busy = busy;
    end
    if (nv < 4) chk("rr_timeout", nv, 4);
    cyc = 0;
    do begin
      step(2'b00, 1'b0);
      cyc++;
    end while (busy && cyc < 20);

    // One vector from requester 0, no backpressure.
    nw = 0; nd = 0; nb = 0; ip = 0;
    for (int i = 0; i < 7; i++) begin
      step((i == 0) ? 2'b01 : 2'b00, 1'b0);
      if (busy) begin
        nb++;
        chk("t2_grant", grant, 2'b01);
      end
      if (wr) nw++;
      if (done) begin
        nd++;
        chk("t2_done_with_wr", wr, 1);
      end
      if (rd) begin
        chk($sformatf("t2_idx%0d", ip), idx, ip);
        ip++;
      end
    end
    chk("t2_pops", ip, 4);
    chk("t2_busy_cycles", nb, 5);
    chk("t2_wr_count", nw, 4);
    chk("t2_done_count", nd, 1);

    // Backpressure for three cycles after the second pop.
    nw = 0; nd = 0;
    for (int i = 0; i < 10; i++) begin
      step((i == 0) ? 2'b01 : 2'b00, af_tab[i]);
      if (af_tab[i]) begin
        chk("t4_stall_rd", rd, 0);
        chk("t4_stall_idx", idx, 2);
      end
      if (i == 3) chk("t4_wr_2nd", wr, 1);
      if (wr) nw++;
      if (done) nd++;
    end
    chk("t4_wr_count", nw, 4);
    chk("t4_done_count", nd, 1);

    // Random readiness and backpressure.
    nv = 0; cyc = 0;
    while (nv < 1000 && cyc < 40000) begin
      step(NR'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
      cyc++;
      if (done) nv++;
    end
    chk("rand_vectors", nv, 1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
